ray_frame_scheduler: RTL and testbench

Sequences per-column ray casting for each video frame and controls the ping-pong ray buffer that feeds the per-pixel colour stage. The block issues one cast request per screen column to the raycaster, captures the returned wall and mob ray words, and writes them into the back bank. At a frame boundary it swaps banks so scanout always reads a complete frame.

---
 rtl/ray_pkg.sv | 48 ++++
 rtl/ray_frame_scheduler.sv | 169 ++++++++++++++++
 tb/tb_ray_frame_scheduler.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ray_pkg.sv
// ----------------------------------------------------------------------------
// ray_pkg
// Shared definitions for the ray-casting frame scheduler and its neighbours:
// scheduler FSM state encoding, default geometry, and the bit-field layout of
// the wall and mob ray words exchanged with the raycaster and the colour stage.
// ----------------------------------------------------------------------------
package ray_pkg;

    localparam int NUM_COLS_DEF = 640;
    localparam int COL_W_DEF    = 10;

    // Fields common to both ray words
    localparam int DIST_MSB = 31;
    localparam int DIST_LSB = 16;

    // Wall ray word
    localparam int TEX_X_MSB   = 7;
    localparam int TEX_X_LSB   = 4;
    localparam int TEX_SEL_MSB = 3;
    localparam int TEX_SEL_LSB = 0;

    // Mob ray word
    localparam int MOB_PRESENT_MSB = 15;
    localparam int MOB_PRESENT_LSB = 12;
    localparam int MOB_X_MSB       = 5;
    localparam int MOB_X_LSB       = 2;
    localparam int MOB_TYPE_MSB    = 1;
    localparam int MOB_TYPE_LSB    = 0;

    // Legacy-compatible numeric state codes, bound into the enum below.
    localparam logic [1:0] ST_IDLE_C  = 2'd0;
    localparam logic [1:0] ST_REQ_C   = 2'd1;
    localparam logic [1:0] ST_WRITE_C = 2'd2;
    localparam logic [1:0] ST_DONE_C  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = ST_IDLE_C,
        ST_REQ   = ST_REQ_C,
        ST_WRITE = ST_WRITE_C,
        ST_DONE  = ST_DONE_C
    } sched_state_t;

    // Saturating 8-bit increment used by the overrun counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/ray_frame_scheduler.sv
// ----------------------------------------------------------------------------
// ray_frame_scheduler
// Issues one cast request per screen column each frame, captures the wall and
// mob ray words returned by the raycaster and writes them into the back bank
// of a ping-pong ray buffer. The displayed bank flips only when a complete
// frame has been written and a new frame starts, so scanout never reads a
// partially cast frame.
//
// Ports
//   Clk, Reset_n        system clock, asynchronous active-low reset
//   frame_start         one-cycle pulse at start of vertical blank
//   vga_x               current scanout column
//   cast_req/cast_col   cast request and column to the raycaster
//   cast_ack            raycaster result valid (ray words valid same cycle)
//   cast_wall_d/mob_d   returned ray words
//   wr_en/wr_addr       back-bank write strobe and {bank, column} address
//   wr_wall_d/wr_mob_d  captured ray words being written
//   rd_addr             {disp_bank, vga_x} read address (combinational)
//   disp_bank           bank currently scanned out
//   frame_done          one-cycle pulse on entry to DONE
//   overrun_cnt         saturating count of frames that missed their deadline
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | after reset; first frame_start starts casting without a swap
// REQ    | cast_req high for column col, waiting for cast_ack
// WRITE  | one-cycle write of the captured words to {~disp_bank, col}
// DONE   | whole frame written; next frame_start swaps banks and restarts
// ----------------------------------------------------------------------------
module ray_frame_scheduler
    import ray_pkg::*;
#(
    parameter int NUM_COLS = NUM_COLS_DEF,
    parameter int COL_W    = COL_W_DEF
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               frame_start,
    input  logic [COL_W-1:0]   vga_x,
    output logic               cast_req,
    output logic [COL_W-1:0]   cast_col,
    input  logic               cast_ack,
    input  logic [31:0]        cast_wall_d,
    input  logic [31:0]        cast_mob_d,
    output logic               wr_en,
    output logic [COL_W:0]     wr_addr,
    output logic [31:0]        wr_wall_d,
    output logic [31:0]        wr_mob_d,
    output logic [COL_W:0]     rd_addr,
    output logic               disp_bank,
    output logic               frame_done,
    output logic [7:0]         overrun_cnt
);

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COLS - 1);

    sched_state_t     state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic             bank_q, bank_d;
    logic [7:0]       ovr_q, ovr_d;
    logic [31:0]      wall_q, wall_d;
    logic [31:0]      mob_q, mob_d;
    logic             done_q, done_d;
    logic             last_col;

    assign last_col = (col_q == LAST_COL);

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        bank_d  = bank_q;
        ovr_d   = ovr_q;
        wall_d  = wall_q;
        mob_d   = mob_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // First frame after reset: nothing valid in either bank yet,
                // so start casting without swapping.
                if (frame_start) begin
                    col_d   = '0;
                    state_d = ST_REQ;
                end
            end

            ST_REQ: begin
                if (cast_ack) begin
                    wall_d  = cast_wall_d;
                    mob_d   = cast_mob_d;
                    state_d = ST_WRITE;
                end
                if (frame_start) begin
                    ovr_d = sat_inc8(ovr_q);
                end
            end

            ST_WRITE: begin
                if (last_col) begin
                    done_d = 1'b1;
                    // A frame_start landing on the final write is treated as
                    // if it had arrived in DONE: swap and restart at once.
                    if (frame_start) begin
                        bank_d  = ~bank_q;
                        col_d   = '0;
                        state_d = ST_REQ;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    col_d   = col_q + 1'b1;
                    state_d = ST_REQ;
                    if (frame_start) begin
                        ovr_d = sat_inc8(ovr_q);
                    end
                end
            end

            ST_DONE: begin
                if (frame_start) begin
                    bank_d  = ~bank_q;
                    col_d   = '0;
                    state_d = ST_REQ;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
            col_q   <= '0;
            bank_q  <= 1'b0;
            ovr_q   <= 8'd0;
            wall_q  <= 32'd0;
            mob_q   <= 32'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            bank_q  <= bank_d;
            ovr_q   <= ovr_d;
            wall_q  <= wall_d;
            mob_q   <= mob_d;
            done_q  <= done_d;
        end
    end

    // Strobes are pure decodes of registered state, so reset clears them
    // asynchronously and cast_req drops without waiting for cast_ack.
    assign cast_req    = (state_q == ST_REQ);
    assign cast_col    = col_q;
    assign wr_en       = (state_q == ST_WRITE);
    assign wr_addr     = {~bank_q, col_q};
    assign wr_wall_d   = wall_q;
    assign wr_mob_d    = mob_q;
    assign disp_bank   = bank_q;
    assign frame_done  = done_q;
    assign overrun_cnt = ovr_q;

    // Out-of-range scanout columns pass straight through; the consumer
    // ignores them.
    assign rd_addr     = {bank_q, vga_x};

endmodule

// File: tb/tb_ray_frame_scheduler.sv
module tb_ray_frame_scheduler;

    logic        Clk;
    logic        Reset_n;
    logic        frame_start;
    logic [9:0]  vga_x;
    logic        cast_req;
    logic [9:0]  cast_col;
    logic        cast_ack;
    logic [31:0] cast_wall_d;
    logic [31:0] cast_mob_d;
    logic        wr_en;
    logic [10:0] wr_addr;
    logic [31:0] wr_wall_d;
    logic [31:0] wr_mob_d;
    logic [10:0] rd_addr;
    logic        disp_bank;
    logic        frame_done;
    logic [7:0]  overrun_cnt;

    int checks = 0;
    int errors = 0;

    ray_frame_scheduler #(.NUM_COLS(640), .COL_W(10)) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .frame_start (frame_start),
        .vga_x       (vga_x),
        .cast_req    (cast_req),
        .cast_col    (cast_col),
        .cast_ack    (cast_ack),
        .cast_wall_d (cast_wall_d),
        .cast_mob_d  (cast_mob_d),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_wall_d   (wr_wall_d),
        .wr_mob_d    (wr_mob_d),
        .rd_addr     (rd_addr),
        .disp_bank   (disp_bank),
        .frame_done  (frame_done),
        .overrun_cnt (overrun_cnt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic        fs;
        logic        ack;
        logic [9:0]  vx;
        logic [31:0] wall;
        logic [31:0] mob;
        logic        e_req;
        logic [9:0]  e_col;
        logic        e_wr;
        logic [10:0] e_waddr;
        logic [31:0] e_wall;
        logic [31:0] e_mob;
        logic        e_disp;
        logic [7:0]  e_ovr;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    initial begin
        int i;
        int done_at;
        int wcnt;
        int bad_addr;
        int bad_disp;
        int last_waddr;
        int stable_bad;
        int wr_bad;
        int extra_bad;
        int req_seen;
        bit final_seen;
        bit hit100;

        //         fs    ack   vx     wall           mob            req   col    wr    waddr   e_wall         e_mob          disp  ovr
        vecs[0]  = '{1'b0, 1'b1, 10'd5,   32'hAAAA_AAAA, 32'hBBBB_BBBB, 1'b0, 10'd0, 1'b0, 11'd0,    32'h0,         32'h0,         1'b0, 8'd0};
        vecs[1]  = '{1'b1, 1'b0, 10'd10,  32'h0,         32'h0,         1'b0, 10'd0, 1'b0, 11'd0,    32'h0,         32'h0,         1'b0, 8'd0};
        vecs[2]  = '{1'b0, 1'b0, 10'd639, 32'h0,         32'h0,         1'b1, 10'd0, 1'b0, 11'd0,    32'h0,         32'h0,         1'b0, 8'd0};
        vecs[3]  = '{1'b0, 1'b1, 10'd0,   32'h1234_00A5, 32'h0800_F03E, 1'b1, 10'd0, 1'b0, 11'd0,    32'h0,         32'h0,         1'b0, 8'd0};
        vecs[4]  = '{1'b0, 1'b1, 10'd700, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b0, 10'd0, 1'b1, 11'd1024, 32'h1234_00A5, 32'h0800_F03E, 1'b0, 8'd0};
        vecs[5]  = '{1'b0, 1'b0, 10'd1,   32'h0,         32'h0,         1'b1, 10'd1, 1'b0, 11'd0,    32'h0,         32'h0,         1'b0, 8'd0};
        vecs[6]  = '{1'b0, 1'b1, 10'd2,   32'h0001_0011, 32'h0002_1007, 1'b1, 10'd1, 1'b0, 11'd0,    32'h0,         32'h0,         1'b0, 8'd0};
        vecs[7]  = '{1'b1, 1'b0, 10'd3,   32'h0,         32'h0,         1'b0, 10'd0, 1'b1, 11'd1025, 32'h0001_0011, 32'h0002_1007, 1'b0, 8'd0};
        vecs[8]  = '{1'b0, 1'b0, 10'd4,   32'h0,         32'h0,         1'b1, 10'd2, 1'b0, 11'd0,    32'h0,         32'h0,         1'b0, 8'd1};
        vecs[9]  = '{1'b0, 1'b1, 10'd5,   32'hFFFF_FFFF, 32'h0,         1'b1, 10'd2, 1'b0, 11'd0,    32'h0,         32'h0,         1'b0, 8'd1};
        vecs[10] = '{1'b0, 1'b0, 10'd6,   32'h0,         32'h0,         1'b0, 10'd0, 1'b1, 11'd1026, 32'hFFFF_FFFF, 32'h0,         1'b0, 8'd1};

        Reset_n     = 1'b0;
        frame_start = 1'b0;
        vga_x       = 10'd0;
        cast_ack    = 1'b0;
        cast_wall_d = 32'h0;
        cast_mob_d  = 32'h0;

        #2;
        chk("reset_cast_req",   32'(cast_req),    32'd0);
        chk("reset_wr_en",      32'(wr_en),       32'd0);
        chk("reset_disp_bank",  32'(disp_bank),   32'd0);
        chk("reset_overrun",    32'(overrun_cnt), 32'd0);
        chk("reset_frame_done", 32'(frame_done),  32'd0);

        tick;
        tick;
        Reset_n = 1'b1;

        // Cycle-by-cycle vectors: start of first frame, ack handling,
        // data capture, overrun in a non-final WRITE.
        for (int v = 0; v < 11; v++) begin
            frame_start = vecs[v].fs;
            cast_ack    = vecs[v].ack;
            vga_x       = vecs[v].vx;
            cast_wall_d = vecs[v].wall;
            cast_mob_d  = vecs[v].mob;
            #2;
            chk($sformatf("v%0d_cast_req", v), 32'(cast_req), 32'(vecs[v].e_req));
            if (vecs[v].e_req)
                chk($sformatf("v%0d_cast_col", v), 32'(cast_col), 32'(vecs[v].e_col));
            chk($sformatf("v%0d_wr_en", v), 32'(wr_en), 32'(vecs[v].e_wr));
            if (vecs[v].e_wr) begin
                chk($sformatf("v%0d_wr_addr", v), 32'(wr_addr),  32'(vecs[v].e_waddr));
                chk($sformatf("v%0d_wr_wall", v), wr_wall_d,     vecs[v].e_wall);
                chk($sformatf("v%0d_wr_mob", v),  wr_mob_d,      vecs[v].e_mob);
            end
            chk($sformatf("v%0d_rd_addr", v), 32'(rd_addr), 32'({vecs[v].e_disp, vecs[v].vx}));
            chk($sformatf("v%0d_disp", v),    32'(disp_bank),   32'(vecs[v].e_disp));
            chk($sformatf("v%0d_ovr", v),     32'(overrun_cnt), 32'(vecs[v].e_ovr));
            chk($sformatf("v%0d_frame_done", v), 32'(frame_done), 32'd0);
            tick;
        end

        // Asynchronous reset mid-cast (now in REQ, column 3).
        frame_start = 1'b0;
        cast_ack    = 1'b0;
        #2;
        Reset_n = 1'b0;
        #1;
        chk("async_rst_cast_req", 32'(cast_req),    32'd0);
        chk("async_rst_col",      32'(cast_col),    32'd0);
        chk("async_rst_overrun",  32'(overrun_cnt), 32'd0);
        chk("async_rst_wall",     wr_wall_d,        32'd0);
        chk("async_rst_mob",      wr_mob_d,         32'd0);
        tick;
        Reset_n  = 1'b1;
        cast_ack = 1'b1;
        req_seen = 0;
        for (int k = 0; k < 4; k++) begin
            #2;
            if (cast_req) req_seen++;
            tick;
        end
        chk("idle_after_reset_req_cycles", 32'(req_seen), 32'd0);

        // Frame 1: ack tied high, full 640-column cast into bank 1.
        frame_start = 1'b1;
        tick;
        frame_start = 1'b0;
        #2;
        chk("f1_first_req", 32'(cast_req), 32'd1);
        i = 0; done_at = -1; wcnt = 0; bad_addr = 0; bad_disp = 0;
        while (i < 3000 && done_at < 0) begin
            if (wr_en) begin
                if (32'(wr_addr) != 32'(1024 + wcnt)) bad_addr++;
                wcnt++;
            end
            if (disp_bank) bad_disp++;
            if (frame_done) done_at = i;
            else begin
                tick;
                #2;
                i++;
            end
        end
        chk("f1_frame_done_cycle", 32'(done_at), 32'd1280);
        chk("f1_write_count",      32'(wcnt),    32'd640);
        chk("f1_bad_addr",         32'(bad_addr), 32'd0);
        chk("f1_bad_disp",         32'(bad_disp), 32'd0);
        tick;
        #2;
        chk("f1_done_no_req",  32'(cast_req),  32'd0);
        chk("f1_done_disp",    32'(disp_bank), 32'd0);

        // Frame 2: frame_start in DONE swaps banks after one cycle.
        frame_start = 1'b1;
        tick;
        frame_start = 1'b0;
        vga_x = 10'd123;
        #2;
        chk("f2_disp_bank", 32'(disp_bank), 32'd1);
        chk("f2_first_req", 32'(cast_req),  32'd1);
        chk("f2_first_col", 32'(cast_col),  32'd0);
        chk("f2_rd_addr",   32'(rd_addr),   32'd1147);
        i = 0; wcnt = 0; bad_addr = 0; final_seen = 1'b0;
        while (i < 3000 && !final_seen) begin
            if (wr_en) begin
                if (32'(wr_addr) != 32'(wcnt)) bad_addr++;
                wcnt++;
                if (wr_addr == 11'd639) final_seen = 1'b1;
            end
            if (!final_seen) begin
                tick;
                #2;
                i++;
            end
        end
        chk("f2_write_count", 32'(wcnt),     32'd640);
        chk("f2_bad_addr",    32'(bad_addr), 32'd0);

        // frame_start coincident with the final WRITE.
        frame_start = 1'b1;
        cast_ack    = 1'b0;
        tick;
        frame_start = 1'b0;
        #2;
        chk("coinc_disp_bank",  32'(disp_bank),   32'd0);
        chk("coinc_cast_req",   32'(cast_req),    32'd1);
        chk("coinc_cast_col",   32'(cast_col),    32'd0);
        chk("coinc_frame_done", 32'(frame_done),  32'd1);
        chk("coinc_overrun",    32'(overrun_cnt), 32'd0);

        // Frame 3: ack delayed to the 5th REQ cycle, stray ack during WRITE.
        stable_bad = 0; wr_bad = 0; extra_bad = 0;
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 5; k++) begin
                if (!(cast_req && 32'(cast_col) == 32'(c))) stable_bad++;
                if (k == 4) cast_ack = 1'b1;
                tick;
                #2;
            end
            if (!(wr_en && 32'(wr_addr) == 32'(1024 + c))) wr_bad++;
            tick;
            cast_ack = 1'b0;
            #2;
            if (wr_en) extra_bad++;
        end
        chk("delay_col_stable", 32'(stable_bad), 32'd0);
        chk("delay_writes",     32'(wr_bad),     32'd0);
        chk("stray_ack_extra",  32'(extra_bad),  32'd0);
        chk("delay_next_col",   32'(cast_col),   32'd4);

        // Overrun at column 100; cast continues to the end without a swap.
        cast_ack = 1'b1;
        i = 0; hit100 = 1'b0;
        while (i < 3000 && !hit100) begin
            if (cast_req && cast_col == 10'd100) hit100 = 1'b1;
            else begin
                tick;
                #2;
                i++;
            end
        end
        frame_start = 1'b1;
        tick;
        frame_start = 1'b0;
        #2;
        chk("ovr100_count", 32'(overrun_cnt), 32'd1);
        chk("ovr100_disp",  32'(disp_bank),   32'd0);
        i = 0; done_at = -1; last_waddr = -1; bad_disp = 0;
        while (i < 3000 && done_at < 0) begin
            if (wr_en) last_waddr = 32'(wr_addr);
            if (disp_bank) bad_disp++;
            if (frame_done) done_at = i;
            else begin
                tick;
                #2;
                i++;
            end
        end
        chk("ovr100_finished",  32'(done_at >= 0), 32'd1);
        chk("ovr100_last_addr", 32'(last_waddr),   32'd1663);
        chk("ovr100_no_swap",   32'(bad_disp),     32'd0);

        // Saturation: frame_start held high while stalled in REQ.
        cast_ack    = 1'b0;
        frame_start = 1'b1;
        tick;
        #2;
        chk("sat_swap_disp", 32'(disp_bank),   32'd1);
        chk("sat_start",     32'(overrun_cnt), 32'd1);
        for (int k = 0; k < 253; k++) tick;
        #2;
        chk("sat_254", 32'(overrun_cnt), 32'd254);
        tick;
        #2;
        chk("sat_255", 32'(overrun_cnt), 32'd255);
        for (int k = 0; k < 10; k++) tick;
        #2;
        chk("sat_hold_255", 32'(overrun_cnt), 32'd255);
        chk("sat_disp_kept", 32'(disp_bank),  32'd1);
        frame_start = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
